replace_policy_unit: RTL

//  Per-set victim selector for the N-way set-associative I/D caches; next generation of
//  the random-only way chooser. Holds per-set replacement state for a compile-time policy:

---
 rtl/replace_policy_unit_pkg.sv | 59 +++++
 rtl/replace_policy_unit_if.sv | 25 ++
 rtl/replace_policy_unit_plru_tree.sv | 40 ++++
 rtl/replace_policy_unit.sv | 114 +++++++++++
 4 files changed

// File: rtl/replace_policy_unit_pkg.sv
// Shared cache replacement package: policy encodings, sizing helpers and the
// small bit-manipulation / LFSR helpers used by the victim selector.
package replace_policy_unit_pkg;

  localparam int unsigned POLICY_RANDOM = 0;
  localparam int unsigned POLICY_PLRU   = 1;
  localparam int unsigned POLICY_FIFO   = 2;

  // Helpers operate on a fixed maximum way count; callers cast to their width.
  localparam int unsigned MAX_WAY = 64;
  typedef logic [MAX_WAY-1:0] way_vec_t;

  function automatic int unsigned plru_bits(input int unsigned num_way);
    return num_way - 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_set);
    return (num_set > 1) ? $clog2(num_set) : 1;
  endfunction

  function automatic way_vec_t isolate_rightmost(input way_vec_t x);
    return x & (~x + MAX_WAY'(1));
  endfunction

  function automatic way_vec_t bin_to_1h(input logic [5:0] b);
    return way_vec_t'(1) << b;
  endfunction

  function automatic logic [5:0] onehot_to_bin(input way_vec_t x);
    logic [5:0] b;
    b = '0;
    for (int unsigned i = 0; i < MAX_WAY; i++) begin
      if (x[i]) b = b | 6'(i);
    end
    return b;
  endfunction

  // Maximal-length Fibonacci tap masks for widths 2..8.
  function automatic logic [7:0] lfsr_taps(input int unsigned w);
    case (w)
      3:       return 8'b0000_0110;
      4:       return 8'b0000_1100;
      5:       return 8'b0001_0100;
      6:       return 8'b0011_0000;
      7:       return 8'b0110_0000;
      8:       return 8'b1011_1000;
      default: return 8'b0000_0011;
    endcase
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] s, input int unsigned w);
    logic [7:0] mask;
    logic       fb;
    mask = (8'(1) << w) - 8'(1);
    fb   = ^(s & lfsr_taps(w));
    return ((s << 1) | {7'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/replace_policy_unit_if.sv
// Query/touch bus between the cache controller and the replacement unit.
interface replace_policy_unit_if #(
  parameter int unsigned NUM_WAY = 4,
  parameter int unsigned IDX_W   = 8
);
  logic [IDX_W-1:0]   query_index;
  logic [NUM_WAY-1:0] v_ways;
  logic [NUM_WAY-1:0] lock_ways;
  logic [NUM_WAY-1:0] replace_way;
  logic               no_victim;
  logic               touch_valid;
  logic               touch_fill;
  logic [IDX_W-1:0]   touch_index;
  logic [NUM_WAY-1:0] touch_way;

  modport master (
    output query_index, v_ways, lock_ways, touch_valid, touch_fill, touch_index, touch_way,
    input  replace_way, no_victim
  );

  modport slave (
    input  query_index, v_ways, lock_ways, touch_valid, touch_fill, touch_index, touch_way,
    output replace_way, no_victim
  );
endinterface

// File: rtl/replace_policy_unit_plru_tree.sv
// Combinational tree pseudo-LRU: victim walk and path update for one set.
module replace_policy_unit_plru_tree
  import replace_policy_unit_pkg::*;
#(
  parameter int unsigned NUM_WAY = 4
) (
  input  logic [NUM_WAY-2:0] tree,
  input  logic [NUM_WAY-1:0] touch_way,
  output logic [NUM_WAY-1:0] victim_c,
  output logic [NUM_WAY-2:0] tree_next_c
);
  localparam int unsigned LVL    = $clog2(NUM_WAY);
  localparam int unsigned NODE_W = (NUM_WAY > 2) ? $clog2(NUM_WAY - 1) : 1;

  // Follow node bits from the root; each bit picks the half holding the victim.
  always_comb begin : victim_walk
    int unsigned node;
    int unsigned way;
    node = 0;
    way  = 0;
    for (int unsigned l = 0; l < LVL; l++) begin
      node = ((32'd1 << l) - 32'd1) + way;
      way  = (way << 1) | 32'(tree[NODE_W'(node)]);
    end
    victim_c = NUM_WAY'(bin_to_1h(6'(way)));
  end

  // Every node on the touched way's path is turned to point at the other half.
  always_comb begin : path_update
    int unsigned node;
    int unsigned touch_bin;
    tree_next_c = tree;
    node        = 0;
    touch_bin   = 32'(onehot_to_bin(MAX_WAY'(touch_way)));
    for (int unsigned l = 0; l < LVL; l++) begin
      node = ((32'd1 << l) - 32'd1) + (touch_bin >> (LVL - l));
      tree_next_c[NODE_W'(node)] = (((touch_bin >> (LVL - 1 - l)) & 32'd1) == 32'd0);
    end
  end
endmodule

// File: rtl/replace_policy_unit.sv
// Per-set victim selector: invalid-first, lock-aware, with compile-time
// RANDOM / PLRU / FIFO replacement state.
module replace_policy_unit
  import replace_policy_unit_pkg::*;
#(
  parameter int unsigned NUM_WAY    = 4,
  parameter int unsigned NUM_SET    = 256,
  parameter int unsigned POLICY     = POLICY_PLRU,
  parameter int unsigned LFSR_WIDTH = $clog2(NUM_WAY) + 2
) (
  input logic                 clk,
  input logic                 reset,
  replace_policy_unit_if.slave bus
);
  localparam int unsigned WAY_W   = $clog2(NUM_WAY);
  localparam int unsigned STATE_W = (POLICY == POLICY_PLRU) ? plru_bits(NUM_WAY) : WAY_W;

  logic [NUM_WAY-1:0] pick_c;
  logic [NUM_WAY-1:0] cand_inv_c;
  logic [NUM_WAY-1:0] unlocked_c;
  logic [NUM_WAY-1:0] pick_ok_c;
  logic               fill_c;

  assign fill_c     = bus.touch_valid & bus.touch_fill;
  assign cand_inv_c = ~bus.v_ways & ~bus.lock_ways;
  assign unlocked_c = ~bus.lock_ways;
  assign pick_ok_c  = pick_c & unlocked_c;

  if (POLICY == POLICY_RANDOM) begin : g_random
    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [LFSR_WIDTH-1:0] lfsr_d;
    logic                  unused_bus;

    assign unused_bus = ^{bus.query_index, bus.touch_index, bus.touch_way};

    always_comb begin
      lfsr_d = lfsr_q;
      if (fill_c) lfsr_d = LFSR_WIDTH'(lfsr_step(8'(lfsr_q), LFSR_WIDTH));
    end

    always_ff @(posedge clk) begin
      if (reset) lfsr_q <= '1;
      else       lfsr_q <= lfsr_d;
    end

    assign pick_c = NUM_WAY'(bin_to_1h(6'(lfsr_q[WAY_W-1:0])));
  end else begin : g_table
    logic [STATE_W-1:0] state_q [NUM_SET];
    logic [STATE_W-1:0] state_d [NUM_SET];
    logic [STATE_W-1:0] query_state_c;
    logic [STATE_W-1:0] touch_state_c;
    logic [STATE_W-1:0] touch_next_c;
    logic               touch_en_c;

    assign query_state_c = state_q[bus.query_index];
    assign touch_state_c = state_q[bus.touch_index];

    if (POLICY == POLICY_PLRU) begin : g_plru
      logic [NUM_WAY-1:0] unused_victim;
      logic [STATE_W-1:0] unused_tree;
      logic               unused_fill;

      assign unused_fill = fill_c;
      assign touch_en_c  = bus.touch_valid;

      replace_policy_unit_plru_tree #(.NUM_WAY(NUM_WAY)) u_query_tree (
        .tree        (query_state_c),
        .touch_way   (NUM_WAY'(0)),
        .victim_c    (pick_c),
        .tree_next_c (unused_tree)
      );

      replace_policy_unit_plru_tree #(.NUM_WAY(NUM_WAY)) u_touch_tree (
        .tree        (touch_state_c),
        .touch_way   (bus.touch_way),
        .victim_c    (unused_victim),
        .tree_next_c (touch_next_c)
      );
    end else begin : g_fifo
      logic unused_way;

      // Pointer advances on any fill, whichever way was actually refilled.
      assign unused_way   = ^bus.touch_way;
      assign touch_en_c   = fill_c;
      assign touch_next_c = touch_state_c + STATE_W'(1);
      assign pick_c       = NUM_WAY'(bin_to_1h(6'(query_state_c)));
    end

    always_comb begin
      state_d = state_q;
      if (touch_en_c) state_d[bus.touch_index] = touch_next_c;
    end

    always_ff @(posedge clk) begin
      if (reset) state_q <= '{default: '0};
      else       state_q <= state_d;
    end
  end

  // Invalid unlocked ways first, then the policy pick, then any unlocked way.
  always_comb begin
    bus.replace_way = '0;
    bus.no_victim   = 1'b0;
    if (&bus.lock_ways) begin
      bus.no_victim = 1'b1;
    end else if (|cand_inv_c) begin
      bus.replace_way = NUM_WAY'(isolate_rightmost(MAX_WAY'(cand_inv_c)));
    end else if (|pick_ok_c) begin
      bus.replace_way = pick_c;
    end else begin
      bus.replace_way = NUM_WAY'(isolate_rightmost(MAX_WAY'(unlocked_c)));
    end
  end
endmodule
